// File: rtl/bcd_convert_stream.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one operand bit per clock,
// with optional two's-complement input, sticky overflow and valid/ready on both sides.
module bcd_convert_stream #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  ovf_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // in_valid/bin_in are only looked at in IDLE; out_valid and the result are held
    // unchanged until the edge on which out_ready is seen high.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] acc;
    logic [BIN_W-1:0] mag;
    logic             sign_r;
    logic             ovf_acc;

    logic [BIN_W-1:0] mag_in;
    logic             sign_in;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] acc_next;
    logic             carry;

    always_comb begin
        sign_in = (SIGNED != 0) && bin_in[BIN_W-1];
        mag_in  = sign_in ? (~bin_in + 1'b1) : bin_in;
    end

    // All digits are corrected from their pre-shift values in parallel; the bit that
    // leaves the top digit is the decimal carry out of the truncated accumulator.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
        end
        carry    = adj[BCD_W-1];
        acc_next = {adj[BCD_W-2:0], mag[BIN_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            sign_out  <= 1'b0;
            ovf_out   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mag       <= '0;
            sign_r    <= 1'b0;
            ovf_acc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mag      <= mag_in;
                        sign_r   <= sign_in;
                        acc      <= '0;
                        ovf_acc  <= 1'b0;
                        cnt      <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc     <= acc_next;
                    mag     <= mag << 1;
                    ovf_acc <= ovf_acc | carry;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bcd_out   <= acc_next;
                        sign_out  <= sign_r;
                        ovf_out   <= ovf_acc | carry;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_stream.sv
// Bench for bcd_convert_stream: three configurations (default, DIGITS=3, SIGNED=1)
// driven by directed and random conversions, checked against an arithmetic model.
module tb_bcd_convert_stream;

    logic        clk;
    logic        rst;
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic [11:0] bin_a       [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic [15:0] bcd_a       [3];
    logic        sign_a      [3];
    logic        ovf_a       [3];

    logic [15:0] bcd0;
    logic [11:0] bcd1;
    logic [15:0] bcd2;

    int n_vec;
    int n_err;

    bcd_convert_stream #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_def (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .bin_in(bin_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .bcd_out(bcd0), .sign_out(sign_a[0]), .ovf_out(ovf_a[0])
    );

    bcd_convert_stream #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u_d3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .bin_in(bin_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .bcd_out(bcd1), .sign_out(sign_a[1]), .ovf_out(ovf_a[1])
    );

    bcd_convert_stream #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .bin_in(bin_a[2]),
        .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .bcd_out(bcd2), .sign_out(sign_a[2]), .ovf_out(ovf_a[2])
    );

    always_comb begin
        bcd_a[0] = bcd0;
        bcd_a[1] = {4'd0, bcd1};
        bcd_a[2] = bcd2;
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: magnitude in decimal, truncated to the instance's digit count.
    task automatic model(input int idx, input logic [11:0] v,
                         output logic [15:0] bcd, output logic s, output logic o);
        int digits;
        int m;
        int pw;
        digits = (idx == 1) ? 3 : 4;
        s = (idx == 2) && (v >= 12'd2048);
        m = s ? (4096 - int'(v)) : int'(v);
        bcd = '0;
        pw = 1;
        for (int i = 0; i < digits; i++) begin
            bcd[4*i +: 4] = 4'((m / pw) % 10);
            pw = pw * 10;
        end
        o = (m >= pw);
    endtask

    task automatic convert(input int idx, input logic [11:0] v, input int hold);
        int lat;
        logic [15:0] eb;
        logic es, eo;
        model(idx, v, eb, es, eo);
        lat = 0;
        while (!in_ready_a[idx] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check_eq("in_ready_wait", 32'(in_ready_a[idx]), 32'd1);
        in_valid_a[idx] = 1'b1;
        bin_a[idx] = v;
        @(posedge clk); #1;
        // in_valid stays high with junk data while busy; it must be ignored
        bin_a[idx] = 12'($urandom);
        check_eq("in_ready_busy", 32'(in_ready_a[idx]), 32'd0);
        lat = 0;
        while (!out_valid_a[idx] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        in_valid_a[idx] = 1'b0;
        check_eq("latency", lat, 32'd12);
        check_eq("bcd", 32'(bcd_a[idx]), 32'(eb));
        check_eq("sign", 32'(sign_a[idx]), 32'(es));
        check_eq("ovf", 32'(ovf_a[idx]), 32'(eo));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(out_valid_a[idx]), 32'd1);
            check_eq("hold_bcd", 32'(bcd_a[idx]), 32'(eb));
            check_eq("hold_in_ready", 32'(in_ready_a[idx]), 32'd0);
        end
        out_ready_a[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[idx] = 1'b0;
        check_eq("release_valid", 32'(out_valid_a[idx]), 32'd0);
        check_eq("release_in_ready", 32'(in_ready_a[idx]), 32'd1);
        check_eq("idle_bcd_held", 32'(bcd_a[idx]), 32'(eb));
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_eq({tag, "_in_ready"}, 32'(in_ready_a[i]), 32'd1);
            check_eq({tag, "_out_valid"}, 32'(out_valid_a[i]), 32'd0);
            check_eq({tag, "_bcd"}, 32'(bcd_a[i]), 32'd0);
            check_eq({tag, "_sign"}, 32'(sign_a[i]), 32'd0);
            check_eq({tag, "_ovf"}, 32'(ovf_a[i]), 32'd0);
        end
    endtask

    task automatic reset_mid_shift();
        int lat;
        int seen;
        lat = 0;
        while (!in_ready_a[0] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        in_valid_a[0] = 1'b1;
        bin_a[0] = 12'd4095;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("mid_rst");
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid_a[0]) seen = 1;
        end
        check_eq("no_result_after_rst", seen, 32'd0);
        convert(0, 12'd371, 0);
    endtask

    logic [11:0] corner [8];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            out_ready_a[i] = 1'b0;
            bin_a[i]       = '0;
        end
        corner[0] = 12'd0;    corner[1] = 12'd999;  corner[2] = 12'd1000;
        corner[3] = 12'd4095; corner[4] = 12'h800;  corner[5] = 12'd2047;
        corner[6] = 12'hFFF;  corner[7] = 12'd1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        convert(0, 12'd24, 0);
        convert(0, 12'd4095, 0);
        convert(0, 12'd0, 0);
        convert(1, 12'd1234, 0);
        convert(1, 12'd999, 0);
        convert(1, 12'd1000, 1);
        convert(2, 12'h800, 0);
        convert(2, 12'hFFF, 0);
        convert(2, 12'd2047, 0);
        convert(0, 12'd2024, 20);
        reset_mid_shift();

        for (int n = 0; n < 30; n++) begin
            int idx;
            logic [11:0] v;
            idx = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) v = corner[$urandom_range(0, 7)];
            else v = 12'($urandom_range(0, 4095));
            convert(idx, v, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
